flag_cond_unit: RTL and testbench

Parametrised flag register and branch-condition evaluator for the processor datapath, the successor to the single-Z-flag jump unit. It holds NFLAGS status flags with per-flag update enables, evaluates a 4-bit condition code against the registered flags to drive the microsequencer jump line, and adds a small flag save/restore stack for call/interrupt entry and return. It sits between the ALU flag outputs and the control store next-address logic.

---
 rtl/flag_cond_unit.sv | 114 +++++++++++
 tb/tb_flag_cond_unit.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/flag_cond_unit.sv
// Flag register with per-flag load enables and a 4-bit branch-condition evaluator.
// Includes a LIFO flag stack for saving and restoring flags on call/interrupt entry and return.
module flag_cond_unit #(
  parameter int NFLAGS      = 4,
  parameter int STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NFLAGS-1:0] flags_in,
  input  logic [NFLAGS-1:0] set_mask,
  input  logic [3:0]        cond_sel,
  input  logic              cond_en,
  input  logic              push,
  input  logic              pop,
  input  logic              err_clr,
  output logic              j_out,
  output logic [NFLAGS-1:0] flags_out,
  output logic              stk_full,
  output logic              stk_empty,
  output logic              stk_err
);
  localparam int CW = $clog2(STACK_DEPTH + 1);
  localparam int AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(STACK_DEPTH);

  logic [NFLAGS-1:0] flags_q, flags_d, loaded_flags;
  logic [CW-1:0]     count_q, count_d;
  logic              stk_err_q, stk_err_d;
  logic [NFLAGS-1:0] stack_mem [2**AW];
  logic [AW-1:0]     wr_idx, rd_idx;
  logic              do_push, do_pop, err_set, cond_hit;
  logic              flag_z, flag_n, flag_c, flag_v;

  assign stk_full  = (count_q == FULL_CNT);
  assign stk_empty = (count_q == '0);

  // Simultaneous push and pop cancel out: no stack movement and no error.
  assign do_push = push & ~pop & ~stk_full;
  assign do_pop  = pop & ~push & ~stk_empty;
  assign err_set = (push & ~pop & stk_full) | (pop & ~push & stk_empty);

  assign wr_idx = count_q[AW-1:0];
  assign rd_idx = AW'(count_q - CW'(1));

  genvar gi;
  generate
    for (gi = 0; gi < NFLAGS; gi++) begin : g_flag_load
      assign loaded_flags[gi] = set_mask[gi] ? flags_in[gi] : flags_q[gi];
    end
  endgenerate

  always_comb begin
    flags_d   = loaded_flags;
    count_d   = count_q;
    stk_err_d = err_set | (stk_err_q & ~err_clr);
    if (do_push) begin
      count_d = count_q + CW'(1);
    end else if (do_pop) begin
      flags_d = stack_mem[rd_idx];
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q   <= '0;
      count_q   <= '0;
      stk_err_q <= 1'b0;
    end else begin
      flags_q   <= flags_d;
      count_q   <= count_d;
      stk_err_q <= stk_err_d;
    end
  end

  // Stack contents are left untouched by reset; the occupancy count alone defines validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      stack_mem[wr_idx] <= flags_q;
    end
  end

  assign flag_z = flags_q[0];
  assign flag_n = flags_q[1];
  assign flag_c = flags_q[2];
  assign flag_v = flags_q[3];

  always_comb begin
    cond_hit = 1'b0;
    case (cond_sel)
      4'd0:  cond_hit = 1'b0;
      4'd1:  cond_hit = 1'b1;
      4'd2:  cond_hit = flag_z;
      4'd3:  cond_hit = ~flag_z;
      4'd4:  cond_hit = flag_n;
      4'd5:  cond_hit = ~flag_n;
      4'd6:  cond_hit = flag_c;
      4'd7:  cond_hit = ~flag_c;
      4'd8:  cond_hit = flag_v;
      4'd9:  cond_hit = ~flag_v;
      4'd10: cond_hit = flag_c & ~flag_z;
      4'd11: cond_hit = ~flag_c | flag_z;
      4'd12: cond_hit = (flag_n == flag_v);
      4'd13: cond_hit = (flag_n != flag_v);
      4'd14: cond_hit = ~flag_z & (flag_n == flag_v);
      4'd15: cond_hit = flag_z | (flag_n != flag_v);
      default: cond_hit = 1'b0;
    endcase
  end

  assign j_out     = cond_en & cond_hit;
  assign flags_out = flags_q;
  assign stk_err   = stk_err_q;
endmodule

// File: tb/tb_flag_cond_unit.sv
// Self-checking bench for flag_cond_unit: constant vector table, directed stack sequences,
// and randomized traffic checked against a queue-based reference model.
module tb_flag_cond_unit;
  localparam int NF = 4;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          clk_run = 1'b0;
  logic          rst;
  logic [NF-1:0] flags_in, set_mask;
  logic [3:0]    cond_sel;
  logic          cond_en, push, pop, err_clr;
  logic          j_out, stk_full, stk_empty, stk_err;
  logic [NF-1:0] flags_out;

  int errors = 0;
  int checks = 0;

  logic [NF-1:0] m_flags;
  logic [NF-1:0] m_stack[$];
  bit            m_err;

  flag_cond_unit #(.NFLAGS(NF), .STACK_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flags_in(flags_in), .set_mask(set_mask),
    .cond_sel(cond_sel), .cond_en(cond_en), .push(push), .pop(pop),
    .err_clr(err_clr), .j_out(j_out), .flags_out(flags_out),
    .stk_full(stk_full), .stk_empty(stk_empty), .stk_err(stk_err)
  );

  always #5 if (clk_run) clk = ~clk;

  typedef struct {
    logic [3:0] flags;
    logic [3:0] sel;
    logic       exp_j;
  } vec_t;

  // Conditions grouped in even/odd pairs; the odd member is the complement of the even one.
  function automatic bit cond_ref(input logic [3:0] sel, input logic [3:0] f);
    bit z, n, c, v, base;
    z = f[0]; n = f[1]; c = f[2]; v = f[3];
    case (sel[3:1])
      3'd0: base = 1'b0;
      3'd1: base = z;
      3'd2: base = n;
      3'd3: base = c;
      3'd4: base = v;
      3'd5: base = c && !z;
      3'd6: base = (n == v);
      default: base = !z && (n == v);
    endcase
    return sel[0] ? !base : base;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".flags"}, 32'(flags_out), 32'(m_flags));
    check({tag, ".full"}, 32'(stk_full), 32'(m_stack.size() == DEPTH));
    check({tag, ".empty"}, 32'(stk_empty), 32'(m_stack.size() == 0));
    check({tag, ".err"}, 32'(stk_err), 32'(m_err));
    check({tag, ".j"}, 32'(j_out), 32'(cond_en && cond_ref(cond_sel, m_flags)));
  endtask

  // One clock edge: advance the model from the inputs present before the edge, then compare.
  task automatic tick(input string tag);
    logic [NF-1:0] nf;
    bit eset;
    eset = 1'b0;
    nf = (m_flags & ~set_mask) | (flags_in & set_mask);
    if (push && !pop) begin
      if (m_stack.size() == DEPTH) eset = 1'b1;
      else m_stack.push_back(m_flags);
    end
    if (pop && !push) begin
      if (m_stack.size() == 0) eset = 1'b1;
      else nf = m_stack.pop_back();
    end
    m_err = eset || (m_err && !err_clr);
    @(posedge clk);
    #1;
    m_flags = nf;
    $display("%s: in=%h mask=%h push=%0d pop=%0d -> flags=%h depth=%0d err=%0d j=%0d",
             tag, flags_in, set_mask, push, pop, flags_out, m_stack.size(), stk_err, j_out);
    check_all(tag);
  endtask

  task automatic idle();
    flags_in = '0; set_mask = '0; push = 0; pop = 0; err_clr = 0;
  endtask

  task automatic load(input logic [3:0] v);
    idle(); flags_in = v; set_mask = 4'hF;
    tick("load");
    idle();
  endtask

  vec_t vecs[22];

  initial begin
    vecs[0]  = '{4'b0010, 4'd12, 1'b0};
    vecs[1]  = '{4'b0010, 4'd13, 1'b1};
    vecs[2]  = '{4'b0010, 4'd14, 1'b0};
    vecs[3]  = '{4'b0000, 4'd0,  1'b0};
    vecs[4]  = '{4'b0000, 4'd1,  1'b1};
    vecs[5]  = '{4'b0000, 4'd15, 1'b0};
    vecs[6]  = '{4'b0000, 4'd11, 1'b1};
    vecs[7]  = '{4'b0100, 4'd10, 1'b1};
    vecs[8]  = '{4'b0100, 4'd11, 1'b0};
    vecs[9]  = '{4'b0100, 4'd6,  1'b1};
    vecs[10] = '{4'b0100, 4'd7,  1'b0};
    vecs[11] = '{4'b0101, 4'd10, 1'b0};
    vecs[12] = '{4'b0101, 4'd11, 1'b1};
    vecs[13] = '{4'b1010, 4'd12, 1'b1};
    vecs[14] = '{4'b1010, 4'd14, 1'b1};
    vecs[15] = '{4'b1010, 4'd15, 1'b0};
    vecs[16] = '{4'b1011, 4'd14, 1'b0};
    vecs[17] = '{4'b1011, 4'd15, 1'b1};
    vecs[18] = '{4'b1011, 4'd2,  1'b1};
    vecs[19] = '{4'b1011, 4'd3,  1'b0};
    vecs[20] = '{4'b1000, 4'd8,  1'b1};
    vecs[21] = '{4'b1000, 4'd13, 1'b1};

    // Reset with the clock stopped.
    idle(); cond_sel = 4'd3; cond_en = 1'b1; rst = 1'b1;
    #2;
    check("rst.flags", 32'(flags_out), 32'h0);
    check("rst.empty", 32'(stk_empty), 32'h1);
    check("rst.full", 32'(stk_full), 32'h0);
    check("rst.err", 32'(stk_err), 32'h0);
    check("rst.j_cond3", 32'(j_out), 32'h1);
    cond_en = 1'b0; #1;
    check("rst.j_dis", 32'(j_out), 32'h0);
    m_flags = '0; m_err = 1'b0; m_stack.delete();
    rst = 1'b0; #1;
    clk_run = 1'b1;
    @(negedge clk);

    // Masked load: jump only sees the flags after the edge.
    flags_in = 4'hF; set_mask = 4'h5; cond_sel = 4'd2; cond_en = 1'b1; #1;
    check("mload.j_same_cycle", 32'(j_out), 32'h0);
    tick("mload");
    check("mload.flags", 32'(flags_out), 32'h5);
    check("mload.j_next", 32'(j_out), 32'h1);

    // Constant vector table.
    for (int i = 0; i < 22; i++) begin
      load(vecs[i].flags);
      cond_sel = vecs[i].sel; cond_en = 1'b1; #1;
      $display("vec %0d: flags=%b sel=%0d -> j=%0d", i, vecs[i].flags, vecs[i].sel, j_out);
      check($sformatf("vec%0d", i), 32'(j_out), 32'(vecs[i].exp_j));
    end

    // Full sweep against the reference model.
    for (int f = 0; f < 16; f++) begin
      load(4'(f));
      for (int s = 0; s < 16; s++) begin
        cond_sel = 4'(s); cond_en = 1'b1; #1;
        check($sformatf("sweep f%0d s%0d", f, s), 32'(j_out), 32'(cond_ref(4'(s), 4'(f))));
      end
    end

    // Fill to depth, overflow, drain, underflow.
    for (int v = 1; v <= 4; v++) begin
      load(4'(v));
      push = 1'b1; tick("push"); idle();
    end
    check("stk.full", 32'(stk_full), 32'h1);
    push = 1'b1; tick("push_ovf"); idle();
    check("stk.ovf_err", 32'(stk_err), 32'h1);
    check("stk.ovf_full", 32'(stk_full), 32'h1);
    for (int v = 4; v >= 1; v--) begin
      pop = 1'b1; tick("pop"); idle();
      check($sformatf("stk.pop%0d", v), 32'(flags_out), 32'(v));
    end
    pop = 1'b1; tick("pop_udf"); idle();
    check("stk.udf_err", 32'(stk_err), 32'h1);
    check("stk.udf_flags", 32'(flags_out), 32'h1);
    check("stk.udf_empty", 32'(stk_empty), 32'h1);

    // Simultaneous events.
    err_clr = 1'b1; tick("errclr"); idle();
    check("sim.err_cleared", 32'(stk_err), 32'h0);
    load(4'h5);
    push = 1'b1; flags_in = 4'hA; set_mask = 4'hF; tick("push_load"); idle();
    check("sim.push_load_flags", 32'(flags_out), 32'hA);
    pop = 1'b1; flags_in = 4'h3; set_mask = 4'hF; tick("pop_load"); idle();
    check("sim.pop_wins", 32'(flags_out), 32'h5);
    push = 1'b1; tick("push"); idle();
    push = 1'b1; pop = 1'b1; tick("push_pop"); idle();
    check("sim.pp_empty", 32'(stk_empty), 32'h0);
    check("sim.pp_err", 32'(stk_err), 32'h0);
    pop = 1'b1; tick("pop"); idle();
    pop = 1'b1; tick("pop_udf"); idle();
    pop = 1'b1; err_clr = 1'b1; tick("pop_udf_clr"); idle();
    check("sim.set_wins", 32'(stk_err), 32'h1);
    err_clr = 1'b1; tick("errclr"); idle();

    // Asynchronous reset between edges with two entries stacked.
    load(4'h7);
    push = 1'b1; tick("push"); idle();
    push = 1'b1; tick("push"); idle();
    #2; rst = 1'b1; #1;
    m_flags = '0; m_err = 1'b0; m_stack.delete();
    check("arst.flags", 32'(flags_out), 32'h0);
    check("arst.empty", 32'(stk_empty), 32'h1);
    check("arst.full", 32'(stk_full), 32'h0);
    rst = 1'b0;
    pop = 1'b1; tick("pop_after_rst"); idle();
    check("arst.pop_err", 32'(stk_err), 32'h1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      flags_in = 4'($urandom);
      set_mask = 4'($urandom);
      push     = ($urandom_range(0, 99) < 35);
      pop      = ($urandom_range(0, 99) < 30);
      err_clr  = ($urandom_range(0, 99) < 10);
      cond_sel = 4'($urandom);
      cond_en  = ($urandom_range(0, 99) < 80);
      tick("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
